ysyx_22050243_regfile_sb: RTL

//  Parametrised multi-port integer register file with write-bypass and a per-register scoreboard.

---
 rtl/ysyx_22050243_rf_pkg.sv | 11 +
 rtl/ysyx_22050243_rf_scoreboard.sv | 60 ++++++
 rtl/ysyx_22050243_regfile_sb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ysyx_22050243_rf_pkg.sv
// Shared types and constants for the ID-stage register file with scoreboard.
package ysyx_22050243_rf_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/ysyx_22050243_rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback or flush.
// rd_busy reports a pending source that the current-cycle writeback cannot bypass.
module ysyx_22050243_rf_scoreboard
    import ysyx_22050243_rf_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // Order matters: clears, then issue (newer producer wins), then flush overrides all.
    always_comb begin
        pend_nxt = pend;
        if (run) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w]) pend_nxt[wr_addr[w*AW +: AW]] = 1'b0;
            end
            if (iss_en && iss_addr != AW'(ZERO_REG)) pend_nxt[iss_addr] = 1'b1;
            if (flush) pend_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pend <= '0;
        else      pend <= pend_nxt;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;

        assign a = rd_addr[p*AW +: AW];

        always_comb begin
            hit = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == a) hit = 1'b1;
            end
        end

        assign rd_busy[p] = run ? (rd_en[p] && a != AW'(ZERO_REG) && pend[a] && !hit) : 1'b1;
    end

endmodule

// File: rtl/ysyx_22050243_regfile_sb.sv
// Multi-port integer register file with write bypass, scoreboard and post-reset clear engine.
// Define REGFILE_DIFFTEST_EN to expose the whole (bypassed) architectural state on gpr_o.
module ysyx_22050243_regfile_sb
    import ysyx_22050243_rf_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
`ifdef REGFILE_DIFFTEST_EN
    ,
    output logic [NREG*XLEN-1:0] gpr_o
`endif
);

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);
    localparam logic [AW-1:0] ZA   = AW'(ZERO_REG);

    rf_state_e       state, state_nxt;
    logic [AW-1:0]   idx;
    logic            run;
    logic [XLEN-1:0] regs [NREG];

    assign run       = (state == RF_RUN);
    assign init_done = run;

    always_ff @(posedge clk) begin
        if (!rst) state <= RF_INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RF_INIT && idx == LAST) state_nxt = RF_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst)                 idx <= '0;
        else if (state == RF_INIT) idx <= idx + AW'(1);
    end

    // Array has no reset of its own; the INIT sweep is what clears it.
    // Ascending port loop makes the highest-index writer win on conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == RF_INIT) begin
                regs[idx] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && wr_addr[w*AW +: AW] != ZA)
                        regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] val;

        assign a = rd_addr[p*AW +: AW];

        always_comb begin
            val = regs[a];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == a) val = wr_data[w*XLEN +: XLEN];
            end
        end

        assign rd_data[p*XLEN +: XLEN] = (run && rd_en[p] && a != ZA) ? val : '0;
    end

    ysyx_22050243_rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

`ifdef REGFILE_DIFFTEST_EN
    assign gpr_o[0 +: XLEN] = '0;
    for (genvar i = 1; i < NREG; i++) begin : g_gpr
        logic [XLEN-1:0] v;
        always_comb begin
            v = regs[i];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(i)) v = wr_data[w*XLEN +: XLEN];
            end
        end
        assign gpr_o[i*XLEN +: XLEN] = run ? v : '0;
    end
`endif

endmodule
